// File: rtl/apb_cmd_master_pkg.sv
// Shared definitions for apb_cmd_master: FSM state encoding and default widths.
package apb_cmd_master_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_ADDR_WIDTH     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_SETUP  = ST_SETUP,
    S_ACCESS = ST_ACCESS,
    S_RESP   = ST_RESP
  } state_e;

endpackage

// File: rtl/apb_cmd_if.sv
// Command/response stream plus APB requester signals; master = apb_cmd_master side.
interface apb_cmd_if
  import apb_cmd_master_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

endinterface

// File: rtl/apb_cmd_master_timeout.sv
// ACCESS wait counter for apb_cmd_master; expired_o flags the TIMEOUT_CYCLES-th
// consecutive cycle without PREADY. Used only with APB_CMD_MASTER_TIMEOUT_EN.
module apb_cmd_timeout #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: clear on entry to ACCESS, step on each unready ACCESS cycle.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The edge that would bring the count to TIMEOUT_CYCLES is the expiry edge.
  assign expired_o = enable_i && (count_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb_cmd_master.sv
// APB requester: one valid/ready command becomes one SETUP/ACCESS transfer and one response.
// Optional ACCESS timeout enabled by defining APB_CMD_MASTER_TIMEOUT_EN.
module apb_cmd_master
  import apb_cmd_master_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic       PCLK,
  input logic       PRESETn,
  apb_cmd_if.master bus_io
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_e                state_q,   state_d;
  logic                  psel_q,    psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q,  pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q,   paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q,  pwdata_d;
  logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
  logic                  err_q,     err_d;
  logic                  timeout_s;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  logic access_wait_s;

  assign access_wait_s = (state_q == S_ACCESS) && !bus_io.PREADY;

  apb_cmd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (PCLK),
    .rst_n    (PRESETn),
    .clear_i  (state_q == S_SETUP),
    .enable_i (access_wait_s),
    .expired_o(timeout_s)
  );
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus_io.cmd_valid) begin
          state_d  = S_SETUP;
          pwrite_d = bus_io.cmd_write;
          paddr_d  = bus_io.cmd_addr;
          pwdata_d = bus_io.cmd_wdata;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        // PREADY is tested first so a same-edge completion beats the timeout.
        if (bus_io.PREADY) begin
          state_d = S_RESP;
          err_d   = bus_io.PSLVERR;
          rdata_d = (pwrite_q || bus_io.PSLVERR) ? '0 : bus_io.PRDATA;
        end else if (timeout_s) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          state_d = S_ACCESS;
        end
      end
      S_RESP: begin
        if (bus_io.rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    psel_d    = (state_d == S_SETUP) || (state_d == S_ACCESS);
    penable_d = (state_d == S_ACCESS);
  end

  // State and output registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= S_IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign bus_io.cmd_ready = (state_q == S_IDLE);
  assign bus_io.rsp_valid = (state_q == S_RESP);
  assign bus_io.rsp_rdata = rdata_q;
  assign bus_io.rsp_err   = err_q;
  assign bus_io.PSEL      = psel_q;
  assign bus_io.PENABLE   = penable_q;
  assign bus_io.PWRITE    = pwrite_q;
  assign bus_io.PADDR     = paddr_q;
  assign bus_io.PWDATA    = pwdata_q;

endmodule

// File: doc/apb_cmd_master.md
# apb_cmd_master

APB requester that converts a simple valid/ready command stream into APB transfers and returns each result on a valid/ready response stream. It sits directly upstream of the APB SRAM slave and is the only master on that APB segment. It drives the SETUP/ACCESS sequence, tolerates any number of PREADY wait states, and reports PSLVERR or an optional timeout as an error response. One transfer is outstanding at a time.

## Interface
- DATA_WIDTH, 8, width of PWDATA/PRDATA and of the command/response data fields
- ADDR_WIDTH, 4, width of PADDR and cmd_addr
- TIMEOUT_CYCLES, 16, ACCESS cycles without PREADY before abort; used only with the timeout feature, legal range ≥2

- PCLK  in  1  clock, all logic on the rising edge
- PRESETn  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and for errored transfers
- rsp_err  out  1  PSLVERR seen, or timeout
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  ADDR_WIDTH  APB address
- PWDATA  out  DATA_WIDTH  APB write data
- PRDATA  in  DATA_WIDTH  APB read data
- PREADY, PSLVERR  in  1 each  APB completion and error

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready = 1.
  - On accept, register cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA, then go to SETUP.
- SETUP: PSEL=1, PENABLE=0. Go to ACCESS unconditionally after one cycle.
- ACCESS:
  - PSEL=1, PENABLE=1.
  - On an edge with PREADY=1: capture PRDATA into rsp_rdata for reads (0 for writes), set rsp_err = PSLVERR, go to RESP.
  - If PSLVERR=1, force rsp_rdata to 0.
- RESP:
  - PSEL=0, PENABLE=0, rsp_valid=1. rsp_rdata and rsp_err are held stable.
  - On rsp_ready, go to IDLE.
- cmd_ready is 0 in every state except IDLE.
- PADDR, PWRITE and PWDATA change only on command accept. They are stable from SETUP through the end of ACCESS.
- Outputs are registered. cmd_ready and rsp_valid decode directly from state flops.

## Timing
- Reset values:
  - State IDLE.
  - PSEL, PENABLE, PWRITE, rsp_valid and rsp_err = 0.
  - PADDR, PWDATA and rsp_rdata = 0.
  - cmd_ready = 1.
- Accept at edge N:
  - SETUP during cycle N+1.
  - ACCESS from N+2.
  - With PREADY first seen high at edge M, rsp_valid is high from M+1.
- Zero-wait slave: minimum 4 cycles from accept to the next cmd_ready.
- Slave with a registered PREADY (one wait state): 5 cycles.
- rsp_ready already high when rsp_valid rises: RESP lasts exactly one cycle, then IDLE.
- rsp_ready low: RESP holds indefinitely. No new command is accepted.
- Reset asserted mid-transfer: PSEL and PENABLE drop immediately (asynchronous). Any pending response is discarded. No response is issued for the aborted command.
- PREADY or PSLVERR high outside ACCESS: ignored.

## Configuration
- APB_CMD_MASTER_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When it reaches TIMEOUT_CYCLES: go to RESP with rsp_err=1 and rsp_rdata=0, and drop PSEL/PENABLE.
  - If PREADY rises on the same edge as the timeout, PREADY wins and the transfer completes normally.
- Undefined: no counter exists. ACCESS waits for PREADY forever.

## Structure
- Shared package apb_cmd_master_pkg contains:
  - State encoding localparams ST_IDLE=2'd0, ST_SETUP=2'd1, ST_ACCESS=2'd2, ST_RESP=2'd3.
  - Default width constants.
- Sub-module apb_cmd_timeout holds the wait counter and the expiry flag.
  - Inputs: enable (= ACCESS && !PREADY) and clear.
  - Instantiated only under APB_CMD_MASTER_TIMEOUT_EN.

## Test plan
- Write then read, with the slave attached: write addr 4'h3 data 8'hA5; next command read addr 4'h3.
  - Expect rsp_err=0 and rsp_rdata=8'h00 for the write, then rsp_rdata=8'hA5 for the read.
  - Check that PSEL precedes PENABLE by exactly one cycle.
- Wait states: slave model holds PREADY low for 3 ACCESS cycles on a read from addr 4'h7 returning 8'h5C.
  - Expect rsp_valid exactly one cycle after PREADY, rsp_rdata=8'h5C.
  - Expect PADDR stable at 4'h7 throughout the transfer.
- Error: PSLVERR=1 with PREADY on a read of 4'hF.
  - Expect rsp_err=1 and rsp_rdata=8'h00.
- Backpressure: hold rsp_ready=0 for 10 cycles with cmd_valid held high.
  - Expect cmd_ready=0, rsp_valid/rsp_rdata/rsp_err stable, and PSEL=0 throughout.
  - After rsp_ready, the second command enters SETUP 2 cycles later.
- Reset mid-ACCESS: drop PRESETn during ACCESS.
  - Expect PSEL=0 and PENABLE=0 immediately, rsp_valid never asserted, cmd_ready=1 after release.
- With APB_CMD_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, PREADY tied low.
  - Expect rsp_err=1 after exactly 16 ACCESS cycles.
  - Repeat with PREADY rising on cycle 16: expect a normal completion.
